// File: rtl/cell_cnt_mod.sv
// Parametrised binary counter cell: up/down, programmable modulo wrap, parallel load,
// synchronous clear, combinational cascade carry (CO) and a registered wrap pulse (TC).
module cell_cnt_mod #(
    parameter int unsigned     WIDTH     = 8,
    parameter longint unsigned MODULO    = 0,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             CK,
    input  logic             CL,
    input  logic [WIDTH-1:0] D,
    input  logic             nL,
    input  logic             nSC,
    input  logic             EN,
    input  logic             CI,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             TC
);

    localparam logic [63:0] TOP64 = (MODULO == 64'd0) ? ((64'd1 << WIDTH) - 64'd1)
                                                      : (MODULO - 64'd1);
    localparam logic [63:0] RST64 = RESET_VAL;
    localparam logic [WIDTH-1:0] TOP  = TOP64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RSTV = RST64[WIDTH-1:0];

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             oor;

    // With the natural modulus every value is in range, so skip the always-false compare.
    generate
        if (MODULO == 64'd0) begin : g_nat
            assign oor = 1'b0;
        end else begin : g_mod
            assign oor = (q_q > TOP);
        end
    endgenerate

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (!nL) begin
            q_d = D;
        end else if (!nSC) begin
            q_d = '0;
        end else if (EN && CI) begin
            if (oor) begin
                q_d  = '0;
                tc_d = 1'b1;
            end else if (UP) begin
                if (q_q == TOP) begin
                    q_d  = '0;
                    tc_d = 1'b1;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    q_d  = TOP;
                    tc_d = 1'b1;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CK or posedge CL) begin
        if (CL) begin
            q_q  <= RSTV;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    // An out-of-range value never equals TOP or 0, so CO stays low there without extra logic.
    assign CO = CI & (UP ? (q_q == TOP) : (q_q == '0));
    assign Q  = q_q;
    assign TC = tc_q;

endmodule

// File: tb/tb_cell_cnt_mod.sv
// Directed bench for cell_cnt_mod: natural and modulo-10 counters, priority, async reset,
// out-of-range recovery, a two-stage cascade and a 1-bit toggle cell.
module tb_cell_cnt_mod;

    logic ck = 1'b0;
    logic cl = 1'b0;

    // 4-bit natural counter
    logic [3:0] d4 = '0;
    logic nl4 = 1'b1, nsc4 = 1'b1, en4 = 1'b0, up4 = 1'b1;
    logic [3:0] q4;
    logic co4, tc4;

    // 4-bit modulo-10 counter, RESET_VAL 4
    logic [3:0] d10 = '0;
    logic nl10 = 1'b1, en10 = 1'b0, up10 = 1'b1;
    logic [3:0] q10;
    logic co10, tc10;

    // cascade pair
    logic [3:0] d_lo = '0, d_hi = '0;
    logic nl_lo = 1'b1, nl_hi = 1'b1, en_lo = 1'b0, en_hi = 1'b0;
    logic [3:0] q_lo, q_hi;
    logic co_lo, co_hi, tc_lo, tc_hi;

    // 1-bit toggle
    logic en1 = 1'b0;
    logic [0:0] d1 = '0;
    logic [0:0] q1;
    logic co1, tc1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 ck = ~ck;

    cell_cnt_mod #(.WIDTH(4), .MODULO(0), .RESET_VAL(0)) u4 (
        .CK(ck), .CL(cl), .D(d4), .nL(nl4), .nSC(nsc4), .EN(en4), .CI(1'b1), .UP(up4),
        .Q(q4), .CO(co4), .TC(tc4));

    cell_cnt_mod #(.WIDTH(4), .MODULO(10), .RESET_VAL(4)) u10 (
        .CK(ck), .CL(cl), .D(d10), .nL(nl10), .nSC(1'b1), .EN(en10), .CI(1'b1), .UP(up10),
        .Q(q10), .CO(co10), .TC(tc10));

    cell_cnt_mod #(.WIDTH(4), .MODULO(0), .RESET_VAL(0)) u_lo (
        .CK(ck), .CL(cl), .D(d_lo), .nL(nl_lo), .nSC(1'b1), .EN(en_lo), .CI(1'b1), .UP(1'b1),
        .Q(q_lo), .CO(co_lo), .TC(tc_lo));

    cell_cnt_mod #(.WIDTH(4), .MODULO(0), .RESET_VAL(0)) u_hi (
        .CK(ck), .CL(cl), .D(d_hi), .nL(nl_hi), .nSC(1'b1), .EN(en_hi), .CI(co_lo), .UP(1'b1),
        .Q(q_hi), .CO(co_hi), .TC(tc_hi));

    cell_cnt_mod #(.WIDTH(1), .MODULO(0), .RESET_VAL(0)) u1 (
        .CK(ck), .CL(cl), .D(d1), .nL(1'b1), .nSC(1'b1), .EN(en1), .CI(1'b1), .UP(1'b1),
        .Q(q1), .CO(co1), .TC(tc1));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #2 cl = 1'b1;
        #4;
        check("rst_q4", 32'(q4), 32'd0);
        check("rst_tc4", 32'(tc4), 32'd0);
        check("rst_q10", 32'(q10), 32'd4);
        check("rst_q1", 32'(q1), 32'd0);
        @(negedge ck);
        cl = 1'b0;

        // natural 4-bit up count through a full wrap
        en4 = 1'b1; up4 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("up_q_%0d", i), 32'(q4), 32'(i % 16));
            check($sformatf("up_tc_%0d", i), 32'(tc4), (i == 16) ? 32'd1 : 32'd0);
            check($sformatf("up_co_%0d", i), 32'(co4), (i == 15) ? 32'd1 : 32'd0);
        end
        en4 = 1'b0;
        tick();
        check("up_hold_q", 32'(q4), 32'd0);
        check("up_tc_one_cycle", 32'(tc4), 32'd0);

        // modulo-10 down count across 0 -> 9
        nl10 = 1'b0; d10 = 4'd3;
        tick();
        check("m10_load_q", 32'(q10), 32'd3);
        nl10 = 1'b1; up10 = 1'b0; en10 = 1'b1;
        begin
            logic [3:0] exp_q[5];
            exp_q = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};
            for (int i = 0; i < 5; i++) begin
                tick();
                check($sformatf("dn_q_%0d", i), 32'(q10), 32'(exp_q[i]));
                check($sformatf("dn_tc_%0d", i), 32'(tc10), (i == 3) ? 32'd1 : 32'd0);
                check($sformatf("dn_co_%0d", i), 32'(co10), (i == 2) ? 32'd1 : 32'd0);
            end
        end
        en10 = 1'b0;

        // load beats clear beats count; then clear beats count
        nl4 = 1'b0; nsc4 = 1'b0; en4 = 1'b1; d4 = 4'd5;
        tick();
        check("prio_load_q", 32'(q4), 32'd5);
        nl4 = 1'b1;
        tick();
        check("prio_clr_q", 32'(q4), 32'd0);
        check("prio_clr_tc", 32'(tc4), 32'd0);
        nsc4 = 1'b1;

        // async reset mid-count
        for (int i = 0; i < 7; i++) tick();
        check("pre_rst_q", 32'(q4), 32'd7);
        #2 cl = 1'b1;
        #1;
        check("async_q4", 32'(q4), 32'd0);
        check("async_tc4", 32'(tc4), 32'd0);
        check("async_q10", 32'(q10), 32'd4);
        tick();
        tick();
        check("rst_hold_q4", 32'(q4), 32'd0);
        #2 cl = 1'b0;
        tick();
        check("resume_q4", 32'(q4), 32'd1);
        en4 = 1'b0;

        // out-of-range load recovers to 0 with TC, in both directions
        nl10 = 1'b0; d10 = 4'd12; en10 = 1'b0; up10 = 1'b1;
        tick();
        check("oor_load_q", 32'(q10), 32'd12);
        check("oor_load_tc", 32'(tc10), 32'd0);
        check("oor_co_up", 32'(co10), 32'd0);
        up10 = 1'b0;
        #1;
        check("oor_co_dn", 32'(co10), 32'd0);
        up10 = 1'b1; nl10 = 1'b1; en10 = 1'b1;
        tick();
        check("oor_up_q", 32'(q10), 32'd0);
        check("oor_up_tc", 32'(tc10), 32'd1);
        nl10 = 1'b0; en10 = 1'b0;
        tick();
        check("oor_reload_q", 32'(q10), 32'd12);
        nl10 = 1'b1; up10 = 1'b0; en10 = 1'b1;
        tick();
        check("oor_dn_q", 32'(q10), 32'd0);
        check("oor_dn_tc", 32'(tc10), 32'd1);
        en10 = 1'b0;

        // cascade: 0x0F -> 0x10
        nl_lo = 1'b0; d_lo = 4'd15; nl_hi = 1'b0; d_hi = 4'd0;
        tick();
        nl_lo = 1'b1; nl_hi = 1'b1; en_lo = 1'b1; en_hi = 1'b1;
        check("cas_lo_co", 32'(co_lo), 32'd1);
        tick();
        check("cas_lo_q", 32'(q_lo), 32'd0);
        check("cas_hi_q", 32'(q_hi), 32'd1);
        // high still steps when low is at 15 but disabled
        nl_lo = 1'b0; d_lo = 4'd15; en_hi = 1'b0;
        tick();
        check("cas_hold_hi", 32'(q_hi), 32'd1);
        nl_lo = 1'b1; en_lo = 1'b0; en_hi = 1'b1;
        tick();
        check("cas_ens_lo", 32'(q_lo), 32'd15);
        check("cas_ens_hi", 32'(q_hi), 32'd2);
        en_hi = 1'b0;

        // 1-bit toggle, TC on each 1 -> 0
        en1 = 1'b1;
        tick();
        check("tgl_q_a", 32'(q1), 32'd1);
        check("tgl_tc_a", 32'(tc1), 32'd0);
        tick();
        check("tgl_q_b", 32'(q1), 32'd0);
        check("tgl_tc_b", 32'(tc1), 32'd1);
        tick();
        check("tgl_q_c", 32'(q1), 32'd1);
        check("tgl_tc_c", 32'(tc1), 32'd0);
        en1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
